// File: rtl/soc_mem.sv
// Bench memory for the PicoRV32 native interface: word SRAM, console port and
// test-result register, with a programmable number of wait cycles per access.
module soc_mem #(
  parameter int MEM_WORDS = 32768,
  parameter int LATENCY   = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tests_passed,
  output logic        console_valid,
  output logic [7:0]  console_char,
  output logic        bus_error
);

  localparam int          AW           = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int          CW           = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
  localparam logic [31:0] SRAM_BYTES   = 32'(4 * MEM_WORDS);
  localparam logic [31:0] CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] RESULT_ADDR  = 32'h2000_0000;
  localparam logic [31:0] PASS_MAGIC   = 32'd123456789;

  logic [31:0]   sram [0:MEM_WORDS-1];
  logic [CW-1:0] r_cnt;

  logic          w_fire;
  logic          w_is_write;
  logic          w_in_sram;
  logic          w_is_console;
  logic          w_is_result;
  logic [AW-1:0] w_word;
  logic [31:0]   w_rd_data;
  logic          w_unused;

  // NOTE: the completion is qualified with reset so that a write whose edge
  // coincides with a held reset never reaches the (unreset) SRAM array.
  assign w_fire       = mem_valid && !mem_ready && (r_cnt == CW'(LATENCY)) && !reset;
  assign w_is_write   = |mem_wstrb;
  assign w_in_sram    = mem_addr < SRAM_BYTES;
  assign w_is_console = mem_addr == CONSOLE_ADDR;
  assign w_is_result  = mem_addr == RESULT_ADDR;
  assign w_word       = mem_addr[AW+1:2];
  assign w_unused     = ^mem_addr[1:0];

  always_comb begin
    w_rd_data = '0;
    if (w_in_sram) begin
      w_rd_data = sram[w_word];
    end else if (w_is_result) begin
      w_rd_data = {31'b0, tests_passed};
    end
  end

  // NOTE: the storage array has no reset so it keeps preloaded/prior contents
  // across reset and maps onto plain RAM.
  always_ff @(posedge clock) begin
    if (w_fire && w_in_sram && w_is_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mem_wstrb[i]) begin
          sram[w_word][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt         <= '0;
      mem_ready     <= 1'b0;
      mem_rdata     <= '0;
      tests_passed  <= 1'b0;
      console_valid <= 1'b0;
      console_char  <= '0;
      bus_error     <= 1'b0;
    end else begin
      mem_ready     <= 1'b0;
      console_valid <= 1'b0;
      if (mem_valid && !mem_ready) begin
        if (w_fire) begin
          r_cnt     <= '0;
          mem_ready <= 1'b1;
          if (!w_is_write) begin
            mem_rdata <= w_rd_data;
          end else if (w_is_console) begin
            console_char  <= mem_wdata[7:0];
            console_valid <= 1'b1;
          end else if (w_is_result && mem_wdata == PASS_MAGIC) begin
            tests_passed <= 1'b1;
          end
          if (!w_in_sram && !w_is_console && !w_is_result) begin
            bus_error <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        // A dropped request, or the ready cycle itself, restarts the wait count.
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_soc_mem.sv
// Directed bench for soc_mem: a zero-latency and a three-cycle instance, with
// read data checked by per-instance scoreboards fed at request issue.
module tb_soc_mem;

  logic        clock;
  logic        reset;

  logic        v0, v3;
  logic [31:0] a0, a3, wd0, wd3;
  logic [3:0]  ws0, ws3;
  logic        ready0, ready3;
  logic [31:0] rdata0, rdata3;
  logic        tp0, tp3, cv0, cv3, be0, be3;
  logic [7:0]  cc0, cc3;

  int total = 0;
  int bad   = 0;

  logic [31:0] q0[$];
  logic [31:0] q3[$];
  logic [31:0] last0 = 32'h0;
  logic [31:0] last3 = 32'h0;

  soc_mem #(.MEM_WORDS(32768), .LATENCY(0)) dut0 (
    .clock(clock), .reset(reset),
    .mem_valid(v0), .mem_ready(ready0), .mem_addr(a0), .mem_wdata(wd0),
    .mem_wstrb(ws0), .mem_rdata(rdata0), .tests_passed(tp0),
    .console_valid(cv0), .console_char(cc0), .bus_error(be0)
  );

  soc_mem #(.MEM_WORDS(32768), .LATENCY(3)) dut3 (
    .clock(clock), .reset(reset),
    .mem_valid(v3), .mem_ready(ready3), .mem_addr(a3), .mem_wdata(wd3),
    .mem_wstrb(ws3), .mem_rdata(rdata3), .tests_passed(tp3),
    .console_valid(cv3), .console_char(cc3), .bus_error(be3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue one request and wait for its ready; n = edges from issue to ready.
  task automatic req(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, input logic [31:0] exp_rd, output int n);
    logic [31:0] exp;
    if (sel) begin
      exp = (wstrb == 4'b0) ? exp_rd : last3;
      last3 = exp;
      q3.push_back(exp);
    end else begin
      exp = (wstrb == 4'b0) ? exp_rd : last0;
      last0 = exp;
      q0.push_back(exp);
    end
    @(posedge clock); #1;
    if (sel) begin v3 = 1'b1; a3 = addr; wd3 = wdata; ws3 = wstrb; end
    else     begin v0 = 1'b1; a0 = addr; wd0 = wdata; ws0 = wstrb; end
    n = 0;
    do begin
      @(posedge clock); #1;
      n++;
    end while (!(sel ? ready3 : ready0) && n < 20);
    if (!(sel ? ready3 : ready0)) check("ready_timeout", 32'(n), 32'(LATENCY_OF(sel) + 1));
    if (sel) begin v3 = 1'b0; ws3 = 4'b0; end
    else     begin v0 = 1'b0; ws0 = 4'b0; end
  endtask

  function automatic int LATENCY_OF(input bit sel);
    return sel ? 3 : 0;
  endfunction

  always @(negedge clock) begin
    if (ready0) begin
      if (q0.size() == 0) check("spurious_ready0", 32'(ready0), 32'h0);
      else                check("rdata0", rdata0, q0.pop_front());
    end
    if (ready3) begin
      if (q3.size() == 0) check("spurious_ready3", 32'(ready3), 32'h0);
      else                check("rdata3", rdata3, q3.pop_front());
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    v0 = 1'b0; a0 = '0; wd0 = '0; ws0 = '0;
    v3 = 1'b0; a3 = '0; wd3 = '0; ws3 = '0;
    dut0.sram[0] = 32'h0000_0013;
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready0", 32'(ready0), 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_outs0", {28'h0, tp0, cv0, be0, ready3}, 32'h0);
    check("rst_char0", 32'(cc0), 32'h0);
    reset = 1'b0;

    // First read with zero latency: ready one edge after valid, low after that.
    req(0, 32'h0, 32'h0, 4'b0, 32'h0000_0013, n);
    check("lat0_edges", 32'(n), 32'd1);
    @(posedge clock); #1;
    check("lat0_ready_drop", 32'(ready0), 32'h0);

    // Byte strobes.
    req(0, 32'h100, 32'hAABB_CCDD, 4'b1111, 32'h0, n);
    req(0, 32'h100, 32'h1122_3344, 4'b0101, 32'h0, n);
    req(0, 32'h100, 32'h0, 4'b0, 32'hAA22_CC44, n);

    // Console pulse.
    req(0, 32'h1000_0000, 32'h0000_0041, 4'b1111, 32'h0, n);
    check("console_valid", 32'(cv0), 32'h1);
    check("console_char", 32'(cc0), 32'h41);
    @(posedge clock); #1;
    check("console_pulse_end", 32'(cv0), 32'h0);
    check("console_char_hold", 32'(cc0), 32'h41);

    // Result register.
    req(0, 32'h2000_0000, 32'h1234_5678, 4'b1111, 32'h0, n);
    check("tp_wrong_magic", 32'(tp0), 32'h0);
    req(0, 32'h2000_0000, 32'd123456789, 4'b1111, 32'h0, n);
    check("tp_magic", 32'(tp0), 32'h1);
    req(0, 32'h2000_0000, 32'h0, 4'b0, 32'h1, n);
    req(0, 32'h1000_0000, 32'h0, 4'b0, 32'h0, n);
    check("no_bus_error_yet", 32'(be0), 32'h0);

    // Unmapped access and SRAM top boundary.
    req(0, 32'h3000_0000, 32'h0, 4'b0, 32'h0, n);
    check("bus_error_set", 32'(be0), 32'h1);
    req(0, 32'h100, 32'h0, 4'b0, 32'hAA22_CC44, n);
    check("bus_error_sticky", 32'(be0), 32'h1);
    req(0, 32'h0001_FFFC, 32'hCAFE_F00D, 4'b1111, 32'h0, n);
    req(0, 32'h0001_FFFC, 32'h0, 4'b0, 32'hCAFE_F00D, n);
    req(0, 32'h0002_0000, 32'h0, 4'b0, 32'h0, n);

    // Three-cycle instance: completion on the fourth edge.
    req(1, 32'h200, 32'h0102_0304, 4'b1111, 32'h0, n);
    req(1, 32'h200, 32'h0, 4'b0, 32'h0102_0304, n);
    check("lat3_edges", 32'(n), 32'd4);
    check("lat3_no_bus_error", 32'(be3), 32'h0);

    // Write abandoned by dropping valid after two edges.
    @(posedge clock); #1;
    v3 = 1'b1; a3 = 32'h200; wd3 = 32'hDEAD_BEEF; ws3 = 4'b1111;
    repeat (2) begin
      @(posedge clock); #1;
      check("abort_no_ready", 32'(ready3), 32'h0);
    end
    v3 = 1'b0; ws3 = 4'b0;
    repeat (3) begin
      @(posedge clock); #1;
      check("abort_no_ready_after", 32'(ready3), 32'h0);
    end
    req(1, 32'h200, 32'h0, 4'b0, 32'h0102_0304, n);

    // Reset during a pending write on each instance.
    req(1, 32'h300, 32'h0A0B_0C0D, 4'b1111, 32'h0, n);
    @(posedge clock); #1;
    v3 = 1'b1; a3 = 32'h300; wd3 = 32'h9999_9999; ws3 = 4'b1111;
    @(posedge clock); #1;
    reset = 1'b1;
    v0 = 1'b1; a0 = 32'h100; wd0 = 32'hFFFF_FFFF; ws0 = 4'b1111;
    #1;
    check("mid_rst_rdata3", rdata3, 32'h0);
    check("mid_rst_rdata0", rdata0, 32'h0);
    check("mid_rst_flags0", {29'h0, tp0, be0, ready3}, 32'h0);
    check("mid_rst_char0", 32'(cc0), 32'h0);
    @(posedge clock); #1;
    check("rst_held_ready0", 32'(ready0), 32'h0);
    v0 = 1'b0; ws0 = 4'b0; v3 = 1'b0; ws3 = 4'b0;
    reset = 1'b0;
    last0 = 32'h0;
    last3 = 32'h0;
    req(1, 32'h300, 32'h0, 4'b0, 32'h0A0B_0C0D, n);
    req(0, 32'h100, 32'h0, 4'b0, 32'hAA22_CC44, n);
    check("post_rst_tp", 32'(tp0), 32'h0);

    repeat (3) @(posedge clock);
    check("sb0_drained", 32'(q0.size()), 32'h0);
    check("sb3_drained", 32'(q3.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
